// File: rtl/washer_pkg.sv
// Shared stage/phase encodings for the washer cycle sequencer.
package washer_pkg;

   // Stage codes are visible on the stage output port.
   typedef enum logic [2:0] {
      STG_IDLE  = 3'd0,
      STG_WASH  = 3'd1,
      STG_RINSE = 3'd2,
      STG_SPIN  = 3'd3,
      STG_DONE  = 3'd4,
      STG_FAULT = 3'd7
   } stage_t;

   // Each timed stage runs clear -> arm -> run.
   typedef enum logic [1:0] {
      PH_CLR = 2'd0,
      PH_ARM = 2'd1,
      PH_RUN = 2'd2
   } phase_t;

   // True for the stages that drive a timer and lock the door.
   function automatic logic stage_is_run(input stage_t s);
      return (s == STG_WASH) || (s == STG_RINSE) || (s == STG_SPIN);
   endfunction

endpackage

// File: rtl/wash_cycle_controller_edge_detect.sv
// Registered 0->1 detector. IDLE_LEVEL sets the remembered level after reset so
// that detecting a fall (by feeding an inverted signal) gives no spurious pulse.
module edge_detect #(
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic CLOCK,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   // Remember last cycle's level.
   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) sig_q <= IDLE_LEVEL;
      else       sig_q <= sig;
   end

   assign rise = sig & ~sig_q;

endmodule

// File: rtl/wash_cycle_controller.sv
// Washer cycle sequencer: WASH -> RINSE x RINSE_REPEATS -> SPIN -> DONE.
// Drives the stage timers' start/reset/pause and muxes the running count to the display.
module wash_cycle_controller
   import washer_pkg::*;
#(
   parameter int unsigned RINSE_REPEATS = 2,
   parameter int unsigned ARM_TIMEOUT   = 8
) (
   input  logic       CLOCK,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       cancel,
   input  logic       door_open,
   input  logic       wash_active,
   input  logic       rinse_active,
   input  logic       spin_active,
   input  logic [3:0] timer_value,
   output logic       wash_start,
   output logic       rinse_start,
   output logic       spin_start,
   output logic       timer_reset,
   output logic       pause,
   output logic [2:0] stage,
   output logic [1:0] rinse_pass,
   output logic [3:0] display_value,
   output logic       door_lock,
   output logic       cycle_done
);

   localparam int unsigned CW = $clog2(ARM_TIMEOUT + 1);

   stage_t          stage_q;
   phase_t          phase_q;
   logic [CW-1:0]   arm_cnt;
   logic            pause_d;
   logic            start_rise;
   logic            wash_fall;
   logic            rinse_fall;
   logic            spin_fall;
   logic            cur_active;
   logic            cur_fall;
   logic            completion;

   edge_detect #(.IDLE_LEVEL(1'b0)) u_start_edge (
      .CLOCK(CLOCK), .reset(reset), .sig(start_btn), .rise(start_rise)
   );

   // Falls are detected as rises of the inverted active; idle level 1 = timer not active.
   edge_detect #(.IDLE_LEVEL(1'b1)) u_wash_fall (
      .CLOCK(CLOCK), .reset(reset), .sig(~wash_active), .rise(wash_fall)
   );
   edge_detect #(.IDLE_LEVEL(1'b1)) u_rinse_fall (
      .CLOCK(CLOCK), .reset(reset), .sig(~rinse_active), .rise(rinse_fall)
   );
   edge_detect #(.IDLE_LEVEL(1'b1)) u_spin_fall (
      .CLOCK(CLOCK), .reset(reset), .sig(~spin_active), .rise(spin_fall)
   );

   // Select the timer belonging to the current stage.
   always_comb begin
      cur_active = 1'b0;
      cur_fall   = 1'b0;
      case (stage_q)
         STG_WASH:  begin cur_active = wash_active;  cur_fall = wash_fall;  end
         STG_RINSE: begin cur_active = rinse_active; cur_fall = rinse_fall; end
         STG_SPIN:  begin cur_active = spin_active;  cur_fall = spin_fall;  end
         default:   begin cur_active = 1'b0;         cur_fall = 1'b0;       end
      endcase
   end

   // A fall only counts as completion when the timer was not paused this or last cycle.
   assign completion = cur_fall & ~pause & ~pause_d;

   assign stage = stage_q;

   // Sequencer state and all registered outputs.
   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         stage_q       <= STG_IDLE;
         phase_q       <= PH_CLR;
         arm_cnt       <= '0;
         pause_d       <= 1'b0;
         wash_start    <= 1'b0;
         rinse_start   <= 1'b0;
         spin_start    <= 1'b0;
         timer_reset   <= 1'b0;
         pause         <= 1'b0;
         rinse_pass    <= '0;
         display_value <= '0;
         door_lock     <= 1'b0;
         cycle_done    <= 1'b0;
      end else begin
         wash_start  <= 1'b0;
         rinse_start <= 1'b0;
         spin_start  <= 1'b0;
         timer_reset <= 1'b0;
         pause       <= door_open & stage_is_run(stage_q);
         pause_d     <= pause;
         if (cancel && (stage_q != STG_IDLE)) begin
            timer_reset   <= 1'b1;
            stage_q       <= STG_IDLE;
            phase_q       <= PH_CLR;
            arm_cnt       <= '0;
            rinse_pass    <= '0;
            display_value <= '0;
            door_lock     <= 1'b0;
            cycle_done    <= 1'b0;
         end else begin
            case (stage_q)
               STG_IDLE: begin
                  display_value <= '0;
                  if (start_rise && !door_open) begin
                     stage_q     <= STG_WASH;
                     phase_q     <= PH_CLR;
                     timer_reset <= 1'b1;
                     door_lock   <= 1'b1;
                  end
               end
               STG_WASH, STG_RINSE, STG_SPIN: begin
                  if (cur_active) display_value <= timer_value;
                  case (phase_q)
                     PH_CLR: begin
                        phase_q <= PH_ARM;
                        arm_cnt <= '0;
                        case (stage_q)
                           STG_WASH:  wash_start  <= 1'b1;
                           STG_RINSE: rinse_start <= 1'b1;
                           default:   spin_start  <= 1'b1;
                        endcase
                     end
                     PH_ARM: begin
                        if (cur_active) begin
                           phase_q <= PH_RUN;
                        end else if (!pause) begin
                           if (arm_cnt == CW'(ARM_TIMEOUT)) begin
                              stage_q       <= STG_FAULT;
                              door_lock     <= 1'b0;
                              rinse_pass    <= '0;
                              display_value <= '0;
                           end else begin
                              arm_cnt <= arm_cnt + 1'b1;
                           end
                        end
                     end
                     PH_RUN: begin
                        if (completion) begin
                           case (stage_q)
                              STG_WASH: begin
                                 stage_q     <= STG_RINSE;
                                 rinse_pass  <= 2'd1;
                                 phase_q     <= PH_CLR;
                                 timer_reset <= 1'b1;
                              end
                              STG_RINSE: begin
                                 phase_q     <= PH_CLR;
                                 timer_reset <= 1'b1;
                                 if (rinse_pass < 2'(RINSE_REPEATS)) begin
                                    rinse_pass <= rinse_pass + 2'd1;
                                 end else begin
                                    stage_q    <= STG_SPIN;
                                    rinse_pass <= '0;
                                 end
                              end
                              default: begin
                                 stage_q       <= STG_DONE;
                                 door_lock     <= 1'b0;
                                 cycle_done    <= 1'b1;
                                 display_value <= '0;
                              end
                           endcase
                        end
                     end
                     default: phase_q <= PH_CLR;
                  endcase
               end
               STG_DONE: begin
                  display_value <= '0;
                  if (start_rise) begin
                     stage_q    <= STG_IDLE;
                     cycle_done <= 1'b0;
                  end
               end
               STG_FAULT: begin
                  display_value <= '0;
               end
               default: begin
                  stage_q <= STG_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Self-checking bench for wash_cycle_controller with behavioural stage timers.
module tb_wash_cycle_controller;

   localparam int RR = 2;
   localparam int AT = 8;

   logic       CLOCK = 1'b0;
   logic       reset, start_btn, cancel, door_open;
   logic       wash_active, rinse_active, spin_active;
   logic [3:0] timer_value;
   logic       wash_start, rinse_start, spin_start, timer_reset, pause;
   logic [2:0] stage;
   logic [1:0] rinse_pass;
   logic [3:0] display_value;
   logic       door_lock, cycle_done;

   int checks = 0;
   int errors = 0;

   // Behavioural timers: act/cnt per timer, inputs seen one cycle late (registered timer).
   bit act[3];
   int cnt[3];
   int ticks[3];
   bit en[3];
   bit s_rst, s_pause;
   bit s_start[3];

   wash_cycle_controller #(.RINSE_REPEATS(RR), .ARM_TIMEOUT(AT)) dut (
      .CLOCK(CLOCK), .reset(reset), .start_btn(start_btn), .cancel(cancel),
      .door_open(door_open), .wash_active(wash_active), .rinse_active(rinse_active),
      .spin_active(spin_active), .timer_value(timer_value), .wash_start(wash_start),
      .rinse_start(rinse_start), .spin_start(spin_start), .timer_reset(timer_reset),
      .pause(pause), .stage(stage), .rinse_pass(rinse_pass), .display_value(display_value),
      .door_lock(door_lock), .cycle_done(cycle_done)
   );

   always #10 CLOCK = ~CLOCK;

   function automatic bit run_stage(input int s);
      return (s == 1) || (s == 2) || (s == 3);
   endfunction

   task automatic drive_timers();
      wash_active  = act[0];
      rinse_active = act[1];
      spin_active  = act[2];
      if (act[0])      timer_value = 4'(cnt[0]);
      else if (act[1]) timer_value = 4'(cnt[1]);
      else if (act[2]) timer_value = 4'(cnt[2]);
      else             timer_value = 4'bz;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin act[i] = 0; cnt[i] = 0; s_start[i] = 0; end
      s_rst = 0; s_pause = 0;
      drive_timers();
   endtask

   // Advance one clock; timers update at the falling edge from last cycle's controls.
   task automatic step();
      @(negedge CLOCK);
      for (int i = 0; i < 3; i++) begin
         if (s_rst) begin
            act[i] = 0; cnt[i] = 0;
         end else if (s_start[i] && en[i]) begin
            act[i] = 1; cnt[i] = ticks[i];
         end else if (act[i] && !s_pause) begin
            if (cnt[i] <= 1) begin act[i] = 0; cnt[i] = 0; end
            else cnt[i] = cnt[i] - 1;
         end
      end
      s_rst = timer_reset; s_pause = pause;
      s_start[0] = wash_start; s_start[1] = rinse_start; s_start[2] = spin_start;
      drive_timers();
   endtask

   task automatic test_reset();
      reset = 1; start_btn = 0; cancel = 0; door_open = 0;
      for (int i = 0; i < 3; i++) begin en[i] = 1; ticks[i] = 3; end
      model_clear();
      step(); step();
      checks++;
      if ({wash_start, rinse_start, spin_start, timer_reset, pause, stage, rinse_pass,
           display_value, door_lock, cycle_done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: stage=%0d disp=%0d lock=%0b tr=%0b want all 0",
                  stage, display_value, door_lock, timer_reset);
      end
      reset = 0;
      step(); step();
      checks++;
      if (stage !== 3'd0) begin
         errors++; $display("FAIL reset_idle: stage=%0d want 0", stage);
      end
   endtask

   task automatic test_full_cycle();
      for (int it = 0; it < 3; it++) begin
         int seq_st[$];
         int seq_ps[$];
         int n_tr = 0, n_st = 0, last_sp = 0, pst = 0;
         bit pact = 0, fin = 0;
         logic [3:0] ptv = 4'd0, pdisp = 4'd0, exp_disp;
         for (int i = 0; i < 3; i++) ticks[i] = (it == 0) ? 3 : int'($urandom_range(3, 9));
         repeat ($urandom_range(1, 4)) step();
         pdisp = display_value;
         start_btn = 1;
         for (int c = 0; c < 400 && !fin; c++) begin
            step();
            if (c == 2) start_btn = 0;
            if ({int'(stage), int'(rinse_pass)} != {pst, last_sp}) begin
               seq_st.push_back(int'(stage)); seq_ps.push_back(int'(rinse_pass));
            end
            if (timer_reset === 1'b1) n_tr++;
            n_st += int'(wash_start) + int'(rinse_start) + int'(spin_start);
            checks++;
            if (door_lock !== run_stage(int'(stage))) begin
               errors++; $display("FAIL door_lock: got %0b want %0b stage %0d",
                                  door_lock, run_stage(int'(stage)), stage);
            end
            if (stage == 3'd0 || stage == 3'd4 || stage == 3'd7) exp_disp = 4'd0;
            else if (run_stage(pst) && pact) exp_disp = ptv;
            else exp_disp = pdisp;
            checks++;
            if (display_value !== exp_disp) begin
               errors++; $display("FAIL display: got %0d want %0d", display_value, exp_disp);
            end
            pst = int'(stage); last_sp = int'(rinse_pass);
            pact = (pst == 1) ? wash_active : (pst == 2) ? rinse_active :
                   (pst == 3) ? spin_active : 1'b0;
            ptv = timer_value; pdisp = display_value;
            if (cycle_done === 1'b1) fin = 1;
         end
         checks++;
         if (!fin) begin errors++; $display("FAIL cycle_timeout: cycle_done never 1"); end
         // Expected visit order: WASH, RINSE pass 1..RR, SPIN, DONE.
         checks++;
         if (seq_st.size() != RR + 3) begin
            errors++; $display("FAIL seq_len: got %0d want %0d", seq_st.size(), RR + 3);
         end else begin
            for (int k = 0; k < RR + 3; k++) begin
               int es, ep;
               es = (k == 0) ? 1 : (k <= RR) ? 2 : (k == RR + 1) ? 3 : 4;
               ep = (k >= 1 && k <= RR) ? k : 0;
               checks++;
               if (seq_st[k] != es || seq_ps[k] != ep) begin
                  errors++; $display("FAIL seq[%0d]: got stage %0d pass %0d want %0d/%0d",
                                     k, seq_st[k], seq_ps[k], es, ep);
               end
            end
         end
         checks++;
         if (n_tr != RR + 2) begin
            errors++; $display("FAIL reset_pulses: got %0d want %0d", n_tr, RR + 2);
         end
         checks++;
         if (n_st != RR + 2) begin
            errors++; $display("FAIL start_pulses: got %0d want %0d", n_st, RR + 2);
         end
         step();
         checks++;
         if (stage !== 3'd4 || cycle_done !== 1'b1) begin
            errors++; $display("FAIL done_hold: stage %0d done %0b want 4/1", stage, cycle_done);
         end
         start_btn = 1; step(); start_btn = 0;
         checks++;
         if (stage !== 3'd0 || cycle_done !== 1'b0) begin
            errors++; $display("FAIL done_exit: stage %0d done %0b want 0/0", stage, cycle_done);
         end
      end
   endtask

   task automatic test_pause();
      bit hit = 0, fin = 0;
      logic [3:0] held;
      logic [2:0] st0;
      logic [1:0] ps0;
      ticks[0] = 3; ticks[1] = 12; ticks[2] = 3;
      step();
      start_btn = 1; step(); start_btn = 0;
      for (int c = 0; c < 100 && !hit; c++) begin
         step();
         if (stage == 3'd2 && rinse_pass == 2'd1 && act[1]) hit = 1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL pause_reach: rinse never active"); end
      repeat ($urandom_range(1, 3)) step();
      door_open = 1;
      checks++;
      if (pause !== 1'b0) begin errors++; $display("FAIL pause_early: got %0b want 0", pause); end
      step();
      checks++;
      if (pause !== 1'b1) begin errors++; $display("FAIL pause_rise: got %0b want 1", pause); end
      st0 = stage; ps0 = rinse_pass;
      step(); step();
      held = display_value;
      for (int c = 3; c < 20; c++) begin
         step();
         checks++;
         if (display_value !== held || stage !== st0 || rinse_pass !== ps0 ||
             door_lock !== 1'b1 || pause !== 1'b1) begin
            errors++;
            $display("FAIL pause_hold: disp %0d/%0d stage %0d/%0d pass %0d/%0d lock %0b pause %0b",
                     display_value, held, stage, st0, rinse_pass, ps0, door_lock, pause);
         end
      end
      door_open = 0;
      step();
      checks++;
      if (pause !== 1'b0) begin errors++; $display("FAIL pause_fall: got %0b want 0", pause); end
      for (int c = 0; c < 300 && !fin; c++) begin
         step();
         if (cycle_done === 1'b1) fin = 1;
      end
      checks++;
      if (!fin) begin errors++; $display("FAIL pause_resume: cycle_done %0b want 1", cycle_done); end
      start_btn = 1; step(); start_btn = 0; step();
   endtask

   task automatic test_door_start();
      int n_st = 0;
      door_open = 1; step();
      start_btn = 1;
      repeat (4) begin
         step();
         n_st += int'(wash_start) + int'(rinse_start) + int'(spin_start) + int'(timer_reset);
      end
      door_open = 0;
      repeat (2) begin
         step();
         n_st += int'(wash_start) + int'(rinse_start) + int'(spin_start) + int'(timer_reset);
      end
      checks++;
      if (stage !== 3'd0) begin errors++; $display("FAIL door_drop: stage %0d want 0", stage); end
      checks++;
      if (n_st != 0) begin errors++; $display("FAIL door_pulses: got %0d want 0", n_st); end
      start_btn = 0; step();
      start_btn = 1; step();
      checks++;
      if (stage !== 3'd1 || door_lock !== 1'b1) begin
         errors++; $display("FAIL door_closed_start: stage %0d lock %0b want 1/1", stage, door_lock);
      end
      cancel = 1; step(); cancel = 0; start_btn = 0;
      checks++;
      if (stage !== 3'd0) begin errors++; $display("FAIL cancel_wash: stage %0d want 0", stage); end
      step();
   endtask

   task automatic test_cancel();
      bit hit = 0;
      int n_tr = 0;
      ticks[0] = 3; ticks[1] = 3; ticks[2] = 10;
      start_btn = 1; step(); start_btn = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         step();
         if (stage == 3'd3 && act[2] && display_value != 4'd0) hit = 1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL cancel_reach: spin never running"); end
      step();
      cancel = 1; step(); cancel = 0;
      checks++;
      if (stage !== 3'd0 || timer_reset !== 1'b1 || door_lock !== 1'b0 || display_value !== 4'd0) begin
         errors++;
         $display("FAIL cancel_spin: stage %0d tr %0b lock %0b disp %0d want 0/1/0/0",
                  stage, timer_reset, door_lock, display_value);
      end
      repeat (4) begin step(); n_tr += int'(timer_reset); end
      checks++;
      if (n_tr != 0) begin errors++; $display("FAIL cancel_single: extra pulses %0d want 0", n_tr); end
   endtask

   task automatic test_fault();
      bit hit = 0;
      en[0] = 0; ticks[0] = 3;
      start_btn = 1; step(); start_btn = 0;
      for (int c = 0; c < 10 && !hit; c++) begin
         if (wash_start === 1'b1) hit = 1; else step();
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL fault_arm: wash_start never pulsed"); end
      // More than AT cycles with no active after the start pulse: FAULT on the (AT+1)th.
      for (int k = 1; k <= AT + 1; k++) begin
         step();
         if (k == AT) begin
            checks++;
            if (stage !== 3'd1) begin errors++; $display("FAIL fault_early: stage %0d want 1", stage); end
         end
      end
      checks++;
      if (stage !== 3'd7 || door_lock !== 1'b0 || display_value !== 4'd0 || cycle_done !== 1'b0) begin
         errors++;
         $display("FAIL fault_enter: stage %0d lock %0b disp %0d want 7/0/0", stage, door_lock, display_value);
      end
      start_btn = 1; step(); step(); start_btn = 0;
      checks++;
      if (stage !== 3'd7) begin errors++; $display("FAIL fault_sticky: stage %0d want 7", stage); end
      cancel = 1; step(); cancel = 0;
      checks++;
      if (stage !== 3'd0) begin errors++; $display("FAIL fault_cancel: stage %0d want 0", stage); end
      en[0] = 1;
      step();
   endtask

   task automatic test_async_reset();
      bit hit = 0;
      ticks[0] = 8;
      start_btn = 1; step(); start_btn = 0;
      for (int c = 0; c < 30 && !hit; c++) begin
         step();
         if (stage == 3'd1 && act[0] && door_lock) hit = 1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL areset_reach: wash never running"); end
      @(posedge CLOCK); #3;
      reset = 1;
      #1;
      checks++;
      if ({wash_start, rinse_start, spin_start, timer_reset, pause, stage, rinse_pass,
           display_value, door_lock, cycle_done} !== '0) begin
         errors++;
         $display("FAIL areset_outputs: stage %0d lock %0b disp %0d want all 0",
                  stage, door_lock, display_value);
      end
      @(negedge CLOCK); reset = 0;
      model_clear();
      step(); step();
      checks++;
      if (stage !== 3'd0) begin errors++; $display("FAIL areset_idle: stage %0d want 0", stage); end
   endtask

   initial begin
      test_reset();
      test_full_cycle();
      test_pause();
      test_door_start();
      test_cancel();
      test_fault();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
